// File: rtl/input_loader_if.sv
// Pixel-stream handshake and x-memory write port of the input loader.
// The loader uses the slave modport; the pixel source / memory side uses master.
interface input_loader_if #(
    parameter int unsigned X_ADDR_LEN = 10,
    parameter int unsigned X_SEL_LEN  = 2,
    parameter int unsigned PIX_WIDTH  = 8
);
    logic                  pix_valid;
    logic [PIX_WIDTH-1:0]  pix_data;
    logic                  pix_ready;
    logic [X_ADDR_LEN-1:0] x_addr;
    logic                  x_data;
    logic [X_SEL_LEN-1:0]  x_sel;
    logic                  x_wq;

    modport master (
        output pix_valid, pix_data,
        input  pix_ready, x_addr, x_data, x_sel, x_wq
    );

    modport slave (
        input  pix_valid, pix_data,
        output pix_ready, x_addr, x_data, x_sel, x_wq
    );
endinterface

// File: rtl/input_loader.sv
// Input loader: streams X1_LEN pixels into x-memory bank 0 as thresholded bits, then runs compute.
// Define LOADER_THRESH_PROG_EN to add a thresh port captured at start; otherwise THRESH is used.
module input_loader #(
    parameter int unsigned X_ADDR_LEN = 10,
    parameter int unsigned X_SEL_LEN  = 2,
    parameter int unsigned X1_LEN     = 784,
    parameter int unsigned PIX_WIDTH  = 8,
    parameter int unsigned THRESH     = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef LOADER_THRESH_PROG_EN
    input  logic [PIX_WIDTH-1:0] thresh,
`endif
    input  logic                 compute_finish,
    output logic                 en,
    output logic                 busy,
    output logic                 load_done,
    input_loader_if.slave        bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StSettle, StRun} state_e;

    localparam logic [X_ADDR_LEN-1:0] LastIdx = X_ADDR_LEN'(X1_LEN - 1);
    localparam logic [PIX_WIDTH-1:0]  ThreshC = PIX_WIDTH'(THRESH);

    state_e                state_q, state_d;
    logic [X_ADDR_LEN-1:0] cnt_q, cnt_d;
    logic [X_ADDR_LEN-1:0] x_addr_q, x_addr_d;
    logic                  x_data_q, x_data_d;
    logic                  x_wq_q, x_wq_d;
    logic                  en_q, en_d;
    logic                  done_q, done_d;
    logic [PIX_WIDTH-1:0]  thr;

`ifdef LOADER_THRESH_PROG_EN
    logic [PIX_WIDTH-1:0] thr_q;

    // Threshold is frozen for the whole image at the accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q <= ThreshC;
        end else if (state_q == StIdle && start) begin
            thr_q <= thresh;
        end
    end
    assign thr = thr_q;
`else
    assign thr = ThreshC;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_addr_d = x_addr_q;
        x_data_d = x_data_q;
        x_wq_d   = 1'b0;
        en_d     = en_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (bus.pix_valid) begin
                    x_addr_d = cnt_q;
                    x_data_d = (bus.pix_data >= thr);
                    x_wq_d   = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_d = StSettle;
                    end
                end
            end
            // One idle cycle lets the last write land before compute is released.
            StSettle: begin
                state_d = StRun;
                en_d    = 1'b1;
            end
            StRun: begin
                if (compute_finish) begin
                    state_d = StIdle;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            x_addr_q <= '0;
            x_data_q <= 1'b0;
            x_wq_q   <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_addr_q <= x_addr_d;
            x_data_q <= x_data_d;
            x_wq_q   <= x_wq_d;
            en_q     <= en_d;
            done_q   <= done_d;
        end
    end

    assign bus.pix_ready = (state_q == StLoad);
    assign bus.x_addr    = x_addr_q;
    assign bus.x_data    = x_data_q;
    assign bus.x_wq      = x_wq_q;
    assign bus.x_sel     = '0;
    assign en            = en_q;
    assign busy          = (state_q != StIdle);
    assign load_done     = done_q;
endmodule

// File: tb/tb_input_loader.sv
// Randomized self-checking bench for input_loader with a transaction-level reference model.
// Also builds with LOADER_THRESH_PROG_EN defined, exercising the programmable threshold.
module tb_input_loader;
    localparam int unsigned XAddrLen = 10;
    localparam int unsigned XSelLen  = 2;
    localparam int unsigned X1Len    = 2;
    localparam int unsigned PixWidth = 8;
    localparam int          Thresh   = 128;

    logic clk            = 1'b0;
    logic rst_n          = 1'b0;
    logic start          = 1'b0;
    logic compute_finish = 1'b0;
    logic en;
    logic busy;
    logic load_done;
`ifdef LOADER_THRESH_PROG_EN
    logic [PixWidth-1:0] thresh = PixWidth'(Thresh);
`endif

    input_loader_if #(
        .X_ADDR_LEN(XAddrLen),
        .X_SEL_LEN (XSelLen),
        .PIX_WIDTH (PixWidth)
    ) bus ();

    input_loader #(
        .X_ADDR_LEN(XAddrLen),
        .X_SEL_LEN (XSelLen),
        .X1_LEN    (X1Len),
        .PIX_WIDTH (PixWidth),
        .THRESH    (Thresh)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
`ifdef LOADER_THRESH_PROG_EN
        .thresh        (thresh),
`endif
        .compute_finish(compute_finish),
        .en            (en),
        .busy          (busy),
        .load_done     (load_done),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int overlap   = 0;
    int last_addr = 0;
    int last_data = 0;
    int dir_valid[$];
    int dir_data[$];

    always @(negedge clk) begin
        if (en && bus.x_wq) overlap++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_wq"}, int'(bus.x_wq), 0);
        check({tag, "_addr"}, int'(bus.x_addr), 0);
        check({tag, "_data"}, int'(bus.x_data), 0);
        check({tag, "_sel"}, int'(bus.x_sel), 0);
        check({tag, "_en"}, int'(en), 0);
        check({tag, "_done"}, int'(load_done), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ready"}, int'(bus.pix_ready), 0);
    endtask

    // Asserts reset between edges and checks outputs clear before any clock edge.
    task automatic mid_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_zero(tag);
        tick();
        start          = 1'b0;
        compute_finish = 1'b0;
        bus.pix_valid  = 1'b0;
        last_addr      = 0;
        last_data      = 0;
        rst_n          = 1'b1;
    endtask

    task automatic start_image(input int thr, output int eff);
        start = 1'b1;
`ifdef LOADER_THRESH_PROG_EN
        thresh = PixWidth'(thr);
        eff    = thr;
`else
        eff = Thresh;
`endif
        tick();
        start = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_ready", int'(bus.pix_ready), 1);
        check("start_wq", int'(bus.x_wq), 0);
    endtask

    // Model: the k-th accepted pixel is written at address k with bit (pixel >= threshold).
    task automatic load_pixels(input int thr, input int n_acc);
        int idx = 0;
        int cyc = 0;
        int v;
        int d;
        while (idx < n_acc && cyc < 200) begin
            if (dir_valid.size() > 0) v = dir_valid.pop_front();
            else v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            if (v != 0 && dir_data.size() > 0) begin
                d = dir_data.pop_front();
            end else begin
                case ($urandom_range(0, 3))
                    0:       d = thr;
                    1:       d = thr - 1;
                    default: d = int'($urandom_range(0, 255));
                endcase
            end
            bus.pix_valid  = (v != 0);
            bus.pix_data   = PixWidth'(d);
            start          = 1'($urandom_range(0, 1));
            compute_finish = 1'($urandom_range(0, 1));
`ifdef LOADER_THRESH_PROG_EN
            thresh = PixWidth'($urandom_range(0, 255));
`endif
            check("ld_ready", int'(bus.pix_ready), 1);
            check("ld_en", int'(en), 0);
            tick();
            if (v != 0) begin
                last_addr = idx;
                last_data = (d >= thr) ? 1 : 0;
                idx++;
            end
            check("ld_wq", int'(bus.x_wq), v);
            check("ld_addr", int'(bus.x_addr), last_addr);
            check("ld_data", int'(bus.x_data), last_data);
            check("ld_busy", int'(busy), 1);
            cyc++;
        end
        bus.pix_valid  = 1'b0;
        start          = 1'b0;
        compute_finish = 1'b0;
        if (idx < n_acc) check("ld_timeout", idx, n_acc);
    endtask

    task automatic finish_image();
        int k;
        check("settle_ready", int'(bus.pix_ready), 0);
        check("settle_en", int'(en), 0);
        check("settle_busy", int'(busy), 1);
        bus.pix_valid = 1'b1;
        start         = 1'($urandom_range(0, 1));
        tick();
        bus.pix_valid = 1'b0;
        check("run_wq", int'(bus.x_wq), 0);
        check("run_en", int'(en), 1);
        check("run_addr", int'(bus.x_addr), last_addr);
        check("run_sel", int'(bus.x_sel), 0);
        k = int'($urandom_range(0, 3));
        for (int i = 0; i < k; i++) begin
            start = 1'($urandom_range(0, 1));
            tick();
            check("run_hold_en", int'(en), 1);
            check("run_hold_busy", int'(busy), 1);
            check("run_hold_done", int'(load_done), 0);
        end
        start          = 1'b0;
        compute_finish = 1'b1;
        tick();
        compute_finish = 1'b0;
        check("fin_en", int'(en), 0);
        check("fin_done", int'(load_done), 1);
        check("fin_busy", int'(busy), 0);
        check("fin_ready", int'(bus.pix_ready), 0);
        tick();
        check("fin_done_pulse", int'(load_done), 0);
        check("fin_idle_busy", int'(busy), 0);
    endtask

    task automatic run_full(input int thr);
        int eff;
        start_image(thr, eff);
        load_pixels(eff, X1Len);
        finish_image();
    endtask

    initial begin
        int eff;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_zero("rst_init");
        rst_n = 1'b1;
        tick();
        check_reset_zero("idle");

        compute_finish = 1'b1;
        tick();
        compute_finish = 1'b0;
        check("idle_finish_done", int'(load_done), 0);
        check("idle_finish_busy", int'(busy), 0);

        // Pixels 200, 50 back to back
        dir_valid = '{1, 1};
        dir_data  = '{200, 50};
        run_full(128);

        // Valid gaps 1,0,0,1
        dir_valid = '{1, 0, 0, 1};
        dir_data  = '{30, 220};
        run_full(128);

        // Threshold boundary
        dir_valid = '{1, 1};
        dir_data  = '{128, 127};
        run_full(128);
`ifdef LOADER_THRESH_PROG_EN
        dir_valid = '{1, 1};
        dir_data  = '{10, 9};
        run_full(10);
`endif

        // Reset after one accept, then a fresh image must start at address 0
        start_image(128, eff);
        dir_valid = '{1};
        load_pixels(eff, 1);
        mid_reset("rst_mid_load");
        dir_valid = '{1, 1};
        run_full(128);

        // Reset during RUN
        start_image(128, eff);
        load_pixels(eff, X1Len);
        tick();
        check("pre_rst_run_en", int'(en), 1);
        mid_reset("rst_mid_run");

        for (int n = 0; n < 30; n++) begin
            run_full(int'($urandom_range(1, 255)));
        end

        check("en_wq_exclusive", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
